// File: rtl/point_stream_renderer.sv
// Point stream renderer: reads a bounded list of packed 3-D points from ZBT
// SRAM, re-times them past the fixed read latency into a small FIFO, and
// presents them with depth shading on a valid/ready stream.
module point_stream_renderer #(
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned COORD_W    = 10,
    parameter int unsigned PIX_W      = 8,
    parameter int unsigned READ_LAT   = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [ADDR_W-1:0]  num_points,
    input  logic [1:0]         mode,
    output logic [ADDR_W-1:0]  zbt0_read_addr,
    input  logic [35:0]        zbt0_read_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic [COORD_W-1:0] out_z,
    output logic [PIX_W-1:0]   out_pixel,
    output logic               busy,
    output logic               done
);

    localparam int unsigned WORD_W = 3 * COORD_W;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned CR_W   = $clog2(FIFO_DEPTH + READ_LAT + 1) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   num_q, num_d;
    logic [ADDR_W-1:0]   issued_q, issued_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          mode_q, mode_d;

    logic [READ_LAT-1:0] tag_q;
    logic [WORD_W-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;

    logic [CR_W-1:0]     inflight;
    logic [CR_W-1:0]     credit_used;
    logic                issue;
    logic                fifo_wr;
    logic                fifo_pop;
    logic                fifo_empty;
    logic [WORD_W-1:0]   head;
    logic [COORD_W-1:0]  head_z;
    logic [PIX_W-1:0]    shade_top;
    logic [PIX_W-1:0]    pixel;

    // Count reads still travelling through the latency pipeline.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < READ_LAT; i++) begin
            inflight = inflight + CR_W'(tag_q[i]);
        end
    end

    // Credit rule: every in-flight read already owns a FIFO slot, so the
    // FIFO can never overflow regardless of downstream backpressure.
    assign credit_used = inflight + CR_W'(count_q);
    assign issue       = (state_q == S_FETCH) && (credit_used < CR_W'(FIFO_DEPTH));
    assign fifo_wr     = tag_q[READ_LAT-1];
    assign fifo_empty  = (count_q == '0);
    assign fifo_pop    = !fifo_empty && out_ready;

    // Pass sequencing, parameter capture and read address generation.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        num_d    = num_q;
        mode_d   = mode_q;
        issued_d = issued_q;
        addr_d   = addr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    num_d    = num_points;
                    mode_d   = mode;
                    issued_d = '0;
                    state_d  = (num_points == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (issue) begin
                    addr_d   = base_q + issued_q;
                    issued_d = issued_q + ADDR_W'(1);
                    if (issued_q == num_q - ADDR_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (inflight == '0 && fifo_empty) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Address is driven combinationally in the issue cycle so the first
    // read leaves one cycle after start; addr_q only holds it afterwards.
    assign zbt0_read_addr = addr_d;
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);

    // Control state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            num_q    <= '0;
            mode_q   <= '0;
            issued_q <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            num_q    <= num_d;
            mode_q   <= mode_d;
            issued_q <= issued_d;
            addr_q   <= addr_d;
        end
    end

    // Read-tag pipeline and FIFO pointers/occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            tag_q[0] <= issue;
            for (int unsigned i = 1; i < READ_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            if (fifo_wr) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({fifo_wr, fifo_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents are never observed while empty.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem_q[wr_ptr_q] <= zbt0_read_data[WORD_W-1:0];
        end
    end

    if (WORD_W < 36) begin : g_unused_hi
        logic unused_word_hi;
        assign unused_word_hi = ^zbt0_read_data[35:WORD_W];
    end

    assign head   = fifo_mem_q[rd_ptr_q];
    assign head_z = head[COORD_W-1:0];

    // Depth-to-intensity shading of the FIFO head.
    always_comb begin
        shade_top = head_z[COORD_W-1 -: PIX_W];
        pixel     = '0;
        case (mode_q)
            2'd0:    pixel = shade_top;
            2'd1:    pixel = ~shade_top;
            2'd2:    pixel = '1;
            default: pixel = ((head_z >> PIX_W) == '0) ? head_z[PIX_W-1:0] : '1;
        endcase
    end

    assign out_valid = !fifo_empty;
    assign out_x     = out_valid ? head[3*COORD_W-1 -: COORD_W] : '0;
    assign out_y     = out_valid ? head[2*COORD_W-1 -: COORD_W] : '0;
    assign out_z     = out_valid ? head_z : '0;
    assign out_pixel = out_valid ? pixel : '0;

endmodule

// File: tb/tb_point_stream_renderer.sv
// Directed bench for point_stream_renderer: a default instance and one with
// READ_LAT=3 / FIFO_DEPTH=8 share stimulus, each with its own SRAM model.
module tb_point_stream_renderer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic [18:0] base_addr = '0;
    logic [18:0] num_points = '0;
    logic [1:0]  mode = '0;

    logic [18:0] a_addr, b_addr;
    logic [35:0] a_rdata, b_rdata;
    logic        a_valid, b_valid, a_busy, b_busy, a_done, b_done;
    logic [9:0]  a_x, a_y, a_z, b_x, b_y, b_z;
    logic [7:0]  a_pix, b_pix;

    int n_checks = 0;
    int n_fail   = 0;
    int ovf      = 0;

    logic [18:0] cur_base = '0;
    logic [9:0]  cur_z = '0;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] z;
        logic [7:0] p;
    } pt_t;

    pt_t qa[$];
    pt_t qb[$];

    always #5 clk = ~clk;

    point_stream_renderer dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .num_points(num_points), .mode(mode), .zbt0_read_addr(a_addr),
        .zbt0_read_data(a_rdata), .out_valid(a_valid), .out_ready(out_ready),
        .out_x(a_x), .out_y(a_y), .out_z(a_z), .out_pixel(a_pix),
        .busy(a_busy), .done(a_done)
    );

    point_stream_renderer #(.READ_LAT(3), .FIFO_DEPTH(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .num_points(num_points), .mode(mode), .zbt0_read_addr(b_addr),
        .zbt0_read_data(b_rdata), .out_valid(b_valid), .out_ready(out_ready),
        .out_x(b_x), .out_y(b_y), .out_z(b_z), .out_pixel(b_pix),
        .busy(b_busy), .done(b_done)
    );

    // SRAM word for an address: x = offset from base, y = 2x, z = cur_z,
    // junk in the unused top bits.
    function automatic logic [35:0] sram_word(input logic [18:0] addr);
        logic [18:0] off;
        off = addr - cur_base;
        return {6'h2A, off[9:0], off[8:0], 1'b0, cur_z};
    endfunction

    logic [18:0] pa [2];
    logic [18:0] pb [3];
    always @(posedge clk) begin
        pa[0] <= a_addr;
        pa[1] <= pa[0];
        pb[0] <= b_addr;
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign a_rdata = sram_word(pa[1]);
    assign b_rdata = sram_word(pb[2]);

    // Transfer capture and FIFO occupancy bound.
    always @(negedge clk) begin
        if (reset_n && a_valid && out_ready) qa.push_back({a_x, a_y, a_z, a_pix});
        if (reset_n && b_valid && out_ready) qb.push_back({b_x, b_y, b_z, b_pix});
        if (int'(dut_a.count_q) > 4 || int'(dut_b.count_q) > 8) ovf++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic run_start(input logic [18:0] b, input logic [18:0] n, input logic [1:0] m);
        @(posedge clk); #1;
        base_addr = b; num_points = n; mode = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; base_addr = ~b; num_points = 19'd7; mode = ~m;
    endtask

    task automatic wait_idle(input int budget, output int da, output int db, output bit to);
        da = 0; db = 0; to = 1'b1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (a_done) da++;
            if (b_done) db++;
            if (!a_busy && !b_busy) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({a_addr, a_valid, a_x, a_y, a_z, a_pix, a_busy, a_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_a: got %h required 0", {a_addr, a_valid, a_x, a_y, a_z, a_pix, a_busy, a_done});
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({b_addr, b_valid, b_x, b_y, b_z, b_pix, b_busy, b_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_b_idle: got %h required 0", {b_addr, b_valid, b_x, b_y, b_z, b_pix, b_busy, b_done});
        end
    endtask

    task automatic test_basic(input string tag);
        int da, db;
        bit to;
        pt_t got;
        cur_base = 19'h100; cur_z = 10'h3FC; out_ready = 1'b1;
        qa.delete(); qb.delete();
        run_start(19'h100, 19'd4, 2'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (a_addr !== 19'h100 + 19'(k - 1)) begin
                n_fail++;
                $display("FAIL %s_addr[%0d]: got %h required %h", tag, k, a_addr, 19'h100 + 19'(k - 1));
            end
            n_checks++;
            if (a_valid !== (k == 4)) begin
                n_fail++;
                $display("FAIL %s_latency[%0d]: valid %b required %b", tag, k, a_valid, (k == 4));
            end
        end
        wait_idle(60, da, db, to);
        n_checks++;
        if (to || da != 1 || db != 1) begin
            n_fail++;
            $display("FAIL %s_done: timeout %b done_a %0d done_b %0d required 0/1/1", tag, to, da, db);
        end
        n_checks++;
        if (qa.size() != 4 || qb.size() != 4) begin
            n_fail++;
            $display("FAIL %s_count: a %0d b %0d required 4", tag, qa.size(), qb.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < qa.size()) ? qa[i] : 'x;
            n_checks++;
            if (got !== {10'(i), 10'(2 * i), 10'h3FC, 8'hFF}) begin
                n_fail++;
                $display("FAIL %s_point_a[%0d]: got %h required %h", tag, i, got, {10'(i), 10'(2 * i), 10'h3FC, 8'hFF});
            end
            got = (i < qb.size()) ? qb[i] : 'x;
            n_checks++;
            if (got !== {10'(i), 10'(2 * i), 10'h3FC, 8'hFF}) begin
                n_fail++;
                $display("FAIL %s_point_b[%0d]: got %h required %h", tag, i, got, {10'(i), 10'(2 * i), 10'h3FC, 8'hFF});
            end
        end
        n_checks++;
        if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy: a %b b %b required 0", tag, a_busy, b_busy);
        end
    endtask

    task automatic test_shading();
        logic [9:0] zt [5];
        logic [1:0] mt [5];
        logic [7:0] pt [5];
        int da, db;
        bit to;
        zt = '{10'h105, 10'h105, 10'h105, 10'h105, 10'h0A5};
        mt = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
        pt = '{8'h41, 8'hBE, 8'hFF, 8'hFF, 8'hA5};
        out_ready = 1'b1; cur_base = 19'h100;
        for (int t = 0; t < 5; t++) begin
            cur_z = zt[t];
            qa.delete(); qb.delete();
            run_start(19'h100, 19'd1, mt[t]);
            wait_idle(40, da, db, to);
            n_checks++;
            if (to || qa.size() != 1 || qb.size() != 1) begin
                n_fail++;
                $display("FAIL shade_count[%0d]: timeout %b a %0d b %0d required 1", t, to, qa.size(), qb.size());
            end else begin
                n_checks++;
                if (qa[0].p !== pt[t] || qb[0].p !== pt[t]) begin
                    n_fail++;
                    $display("FAIL shade[%0d] z=%h mode=%0d: a %h b %h required %h", t, zt[t], mt[t], qa[0].p, qb[0].p, pt[t]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int da, db, maxoff, stab_err;
        bit to;
        logic [18:0] off;
        pt_t got;
        cur_base = 19'h200; cur_z = 10'h3FC; out_ready = 1'b0;
        qa.delete(); qb.delete();
        maxoff = 0; stab_err = 0;
        run_start(19'h200, 19'd10, 2'd0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            off = a_addr - 19'h200;
            if (int'(off) > maxoff) maxoff = int'(off);
            if (k >= 4 && (a_valid !== 1'b1 || a_x !== 10'd0 || a_y !== 10'd0)) stab_err++;
        end
        n_checks++;
        if (maxoff != 3 || a_addr !== 19'h203) begin
            n_fail++;
            $display("FAIL bp_reads: max offset %0d addr %h required 3 / 00203", maxoff, a_addr);
        end
        n_checks++;
        if (stab_err != 0) begin
            n_fail++;
            $display("FAIL bp_hold: %0d unstable cycles required 0", stab_err);
        end
        n_checks++;
        if (qa.size() != 0) begin
            n_fail++;
            $display("FAIL bp_no_xfer: got %0d transfers required 0", qa.size());
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_idle(100, da, db, to);
        n_checks++;
        if (to || da != 1 || db != 1 || qa.size() != 10 || qb.size() != 10) begin
            n_fail++;
            $display("FAIL bp_complete: timeout %b done %0d/%0d count %0d/%0d required 0 1/1 10/10", to, da, db, qa.size(), qb.size());
        end
        for (int i = 0; i < 10; i++) begin
            got = (i < qa.size()) ? qa[i] : 'x;
            n_checks++;
            if (got !== {10'(i), 10'(2 * i), 10'h3FC, 8'hFF}) begin
                n_fail++;
                $display("FAIL bp_point[%0d]: got %h required %h", i, got, {10'(i), 10'(2 * i), 10'h3FC, 8'hFF});
            end
        end
    endtask

    task automatic test_wrap();
        logic [18:0] at [4];
        int da, db;
        bit to;
        at = '{19'h7FFFE, 19'h7FFFF, 19'h00000, 19'h00001};
        cur_base = 19'h7FFFE; cur_z = 10'h3FC; out_ready = 1'b1;
        qa.delete(); qb.delete();
        run_start(19'h7FFFE, 19'd4, 2'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (a_addr !== at[k]) begin
                n_fail++;
                $display("FAIL wrap_addr[%0d]: got %h required %h", k, a_addr, at[k]);
            end
        end
        wait_idle(60, da, db, to);
        n_checks++;
        if (to || qa.size() != 4 || qa[3] !== {10'd3, 10'd6, 10'h3FC, 8'hFF}) begin
            n_fail++;
            $display("FAIL wrap_data: timeout %b count %0d required 4 points ending x=3", to, qa.size());
        end
    endtask

    task automatic test_zero_points();
        logic [18:0] prev;
        int dcount, dcyc, addr_err;
        prev = a_addr; dcount = 0; dcyc = -1; addr_err = 0;
        qa.delete();
        run_start(19'h300, 19'd0, 2'd0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (a_done) begin
                dcount++;
                if (dcyc < 0) dcyc = k;
            end
            if (a_addr !== prev) addr_err++;
        end
        n_checks++;
        if (dcount != 1 || dcyc < 1 || dcyc > 2) begin
            n_fail++;
            $display("FAIL zero_done: pulses %0d first cycle %0d required 1 pulse within 2 cycles", dcount, dcyc);
        end
        n_checks++;
        if (addr_err != 0 || qa.size() != 0 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reads: addr changes %0d points %0d busy %b required 0 0 0", addr_err, qa.size(), a_busy);
        end
    endtask

    task automatic test_start_while_busy();
        int da, db, busy_cnt;
        bit to;
        pt_t got;
        cur_base = 19'h100; cur_z = 10'h3FC; out_ready = 1'b1;
        qa.delete(); qb.delete();
        run_start(19'h100, 19'd6, 2'd0);
        repeat (2) @(negedge clk);
        run_start(19'h400, 19'd2, 2'd1);
        wait_idle(80, da, db, to);
        n_checks++;
        if (to || da != 1 || qa.size() != 6) begin
            n_fail++;
            $display("FAIL busy_start_count: timeout %b done %0d points %0d required 0 1 6", to, da, qa.size());
        end
        for (int i = 0; i < 6; i++) begin
            got = (i < qa.size()) ? qa[i] : 'x;
            n_checks++;
            if (got !== {10'(i), 10'(2 * i), 10'h3FC, 8'hFF}) begin
                n_fail++;
                $display("FAIL busy_start_point[%0d]: got %h required %h", i, got, {10'(i), 10'(2 * i), 10'h3FC, 8'hFF});
            end
        end
        busy_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (a_busy || b_busy) busy_cnt++;
        end
        n_checks++;
        if (busy_cnt != 0) begin
            n_fail++;
            $display("FAIL busy_start_rearm: busy for %0d cycles required 0", busy_cnt);
        end
    endtask

    task automatic test_mid_reset();
        int dcount, busy_cnt;
        cur_base = 19'h100; cur_z = 10'h3FC; out_ready = 1'b0;
        run_start(19'h100, 19'd10, 2'd0);
        repeat (8) @(negedge clk);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({a_addr, a_valid, a_x, a_y, a_z, a_pix, a_busy, a_done,
             b_addr, b_valid, b_x, b_y, b_z, b_pix, b_busy, b_done} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: a %h b %h required 0",
                     {a_addr, a_valid, a_x, a_y, a_z, a_pix, a_busy, a_done},
                     {b_addr, b_valid, b_x, b_y, b_z, b_pix, b_busy, b_done});
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        dcount = 0; busy_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (a_done || b_done) dcount++;
            if (a_busy || b_busy) busy_cnt++;
        end
        n_checks++;
        if (dcount != 0 || busy_cnt != 0) begin
            n_fail++;
            $display("FAIL midreset_abandon: done %0d busy %0d required 0 0", dcount, busy_cnt);
        end
        test_basic("post_reset");
    endtask

    task automatic test_fifo_bound();
        n_checks++;
        if (ovf != 0) begin
            n_fail++;
            $display("FAIL fifo_bound: %0d cycles over depth required 0", ovf);
        end
    endtask

    initial begin
        test_reset();
        test_basic("basic");
        test_shading();
        test_backpressure();
        test_wrap();
        test_zero_points();
        test_start_while_busy();
        test_mid_reset();
        test_fifo_bound();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
